// File: rtl/reloj_ctrl.sv
// Mode/button controller for a clock-stopwatch: synchronizes and debounces two buttons, steps the display mode and issues adjust/stopwatch commands.
// Optional blinking of the digits under adjustment is enabled with the RELOJ_CTRL_BLINK_EN macro.
module reloj_ctrl #(
   parameter int DEB_CYCLES  = 4,
   parameter int LONG_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn1,
   input  logic       btn2,
   input  logic       blink_tick,
   output logic [1:0] sel,
   output logic       crono_run,
   output logic       crono_clr,
   output logic       inc_min,
   output logic       inc_seg,
   output logic       blank
);

   typedef enum logic [1:0] {
      RELOJ  = 2'd0,
      CRONO  = 2'd1,
      AJ_MIN = 2'd2,
      AJ_SEG = 2'd3
   } state_t;

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);

   logic [1:0]    raw;
   logic [1:0]    s1, s2, deb, d1, d2, press;
   logic          rel2;
   logic [DW-1:0] cnt [2];

   state_t        state;
   logic [HW-1:0] hold;
   logic          long_done;

   assign raw = {btn2, btn1};
   assign sel = state;

   // Bit 0 is btn1, bit 1 is btn2. d1/d2 delay the debounced level so the
   // press pulse lands DEB_CYCLES+3 cycles after the first raw sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= '0;
         s2    <= '0;
         deb   <= '0;
         d1    <= '0;
         d2    <= '0;
         press <= '0;
         rel2  <= 1'b0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         d1    <= deb;
         d2    <= d1;
         press <= d1 & ~d2;
         rel2  <= ~d1[1] & d2[1];
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
               deb[i] <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // A btn1 press takes priority and swallows any btn2 event of the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RELOJ;
         crono_run <= 1'b0;
         crono_clr <= 1'b0;
         inc_min   <= 1'b0;
         inc_seg   <= 1'b0;
         hold      <= '0;
         long_done <= 1'b0;
      end else begin
         crono_clr <= 1'b0;
         inc_min   <= 1'b0;
         inc_seg   <= 1'b0;
         if (press[0]) begin
            state     <= state_t'(state + 2'd1);
            hold      <= '0;
            long_done <= 1'b0;
         end else begin
            case (state)
               CRONO: begin
                  if (rel2) begin
                     if (!long_done) crono_run <= ~crono_run;
                     hold      <= '0;
                     long_done <= 1'b0;
                  end else if (d2[1] && hold != HW'(LONG_CYCLES)) begin
                     hold <= hold + 1'b1;
                     if (hold == HW'(LONG_CYCLES - 1)) begin
                        crono_clr <= 1'b1;
                        crono_run <= 1'b0;
                        long_done <= 1'b1;
                     end
                  end
               end
               AJ_MIN:  if (press[1]) inc_min <= 1'b1;
               AJ_SEG:  if (press[1]) inc_seg <= 1'b1;
               default: ;
            endcase
         end
      end
   end

`ifdef RELOJ_CTRL_BLINK_EN
   // Blank only blinks while adjusting; any mode change restarts it visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blank <= 1'b0;
      end else if (press[0]) begin
         blank <= 1'b0;
      end else if (state == AJ_MIN || state == AJ_SEG) begin
         if (blink_tick) blank <= ~blank;
      end else begin
         blank <= 1'b0;
      end
   end
`else
   logic unused_blink;
   assign unused_blink = blink_tick;
   assign blank        = 1'b0;
`endif

endmodule
